// File: rtl/pa_perips_timer_mc_if.sv
// Peripheral register bus bundle for the multi-channel timer: byte-addressed
// read/write strobes, write data, registered read data and interrupt outputs.
interface pa_perips_timer_mc_if #(
  parameter int CH_NUM = 4
) ();
  logic [7:0]        addr_i;
  logic              data_rd_i;
  logic              data_we_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic              irq_o;
  logic [CH_NUM-1:0] irq_vec_o;

  modport master (
    output addr_i, data_rd_i, data_we_i, data_i,
    input  data_o, irq_o, irq_vec_o
  );

  modport slave (
    input  addr_i, data_rd_i, data_we_i, data_i,
    output data_o, irq_o, irq_vec_o
  );
endinterface

// File: rtl/pa_perips_timer_mc.sv
// Multi-channel peripheral timer: CH_NUM prescaled down-counters with
// periodic/one-shot mode, W1C event flags, masked IRQ and phase-aligned start.
module pa_perips_timer_mc #(
  parameter int CH_NUM    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pa_perips_timer_mc_if.slave   bus
);

  localparam logic [7:0] A_GSTART = 8'h00;
  localparam logic [7:0] A_ISR    = 8'h04;
  localparam logic [7:0] A_IER    = 8'h08;

  logic [CH_NUM-1:0]    en_q, en_d, oneshot_q, oneshot_d;
  logic [CH_NUM-1:0]    isr_q, isr_d, ier_q, ier_d;
  logic [CH_NUM-1:0]    irq_vec_q, irq_vec_d;
  logic                 irq_q, irq_d;
  logic [PSC_WIDTH-1:0] psc_q [CH_NUM];
  logic [PSC_WIDTH-1:0] psc_d [CH_NUM];
  logic [PSC_WIDTH-1:0] pcnt_q [CH_NUM];
  logic [PSC_WIDTH-1:0] pcnt_d [CH_NUM];
  logic [CNT_WIDTH-1:0] load_q [CH_NUM];
  logic [CNT_WIDTH-1:0] load_d [CH_NUM];
  logic [CNT_WIDTH-1:0] count_q [CH_NUM];
  logic [CNT_WIDTH-1:0] count_d [CH_NUM];
  logic [31:0]          data_o_q, data_o_d, rdata_s;

  logic [CH_NUM-1:0]    ch_hit_s, tick_s, evt_s;
  logic                 wr_gstart_s, wr_isr_s, wr_ier_s;
  logic                 unused_s;

  // Write data bits beyond the configured field widths are deliberately dropped.
  assign unused_s = ^bus.data_i;

  assign bus.data_o    = data_o_q;
  assign bus.irq_o     = irq_q;
  assign bus.irq_vec_o = irq_vec_q;

  // Address decode plus per-channel prescaler tick and counter event detect.
  always_comb begin
    wr_gstart_s = bus.data_we_i && (bus.addr_i == A_GSTART);
    wr_isr_s    = bus.data_we_i && (bus.addr_i == A_ISR);
    wr_ier_s    = bus.data_we_i && (bus.addr_i == A_IER);
    for (int c = 0; c < CH_NUM; c++) begin
      ch_hit_s[c] = (bus.addr_i[7:4] == 4'(c + 1)) && (bus.addr_i[1:0] == 2'b00);
      tick_s[c]   = (pcnt_q[c] == psc_q[c]);
      evt_s[c]    = en_q[c] && tick_s[c] && (count_q[c] == {CNT_WIDTH{1'b0}});
    end
  end

  // Channel next state: counting first, then GSTART, then CR writes override.
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    psc_d     = psc_q;
    load_d    = load_q;
    count_d   = count_q;
    pcnt_d    = pcnt_q;
    for (int c = 0; c < CH_NUM; c++) begin
      if (en_q[c]) begin
        if (tick_s[c]) begin
          pcnt_d[c] = {PSC_WIDTH{1'b0}};
          if (count_q[c] != {CNT_WIDTH{1'b0}}) begin
            count_d[c] = count_q[c] - CNT_WIDTH'(1);
          end else if (oneshot_q[c]) begin
            en_d[c] = 1'b0;
          end else begin
            count_d[c] = load_q[c];
          end
        end else begin
          pcnt_d[c] = pcnt_q[c] + PSC_WIDTH'(1);
        end
      end else begin
        pcnt_d[c] = {PSC_WIDTH{1'b0}};
      end

      if (wr_gstart_s && bus.data_i[c] && !en_q[c]) begin
        en_d[c]    = 1'b1;
        count_d[c] = load_q[c];
        pcnt_d[c]  = {PSC_WIDTH{1'b0}};
      end else begin
        en_d[c] = en_d[c];
      end

      if (bus.data_we_i && ch_hit_s[c]) begin
        case (bus.addr_i[3:2])
          2'b00: begin
            en_d[c]      = bus.data_i[0];
            oneshot_d[c] = bus.data_i[1];
            // A one-shot that expires in this cycle counts as idle, so EN=1 restarts it.
            if (bus.data_i[0] && (!en_q[c] || (evt_s[c] && oneshot_q[c]))) begin
              count_d[c] = load_q[c];
              pcnt_d[c]  = {PSC_WIDTH{1'b0}};
            end else begin
              count_d[c] = count_d[c];
            end
          end
          2'b01:   psc_d[c]  = bus.data_i[PSC_WIDTH-1:0];
          2'b10:   load_d[c] = bus.data_i[CNT_WIDTH-1:0];
          default: count_d[c] = count_d[c];
        endcase
      end else begin
        load_d[c] = load_d[c];
      end
    end
  end

  // Event flags (set beats W1C), enables and the masked interrupt outputs.
  always_comb begin
    if (wr_isr_s) begin
      isr_d = (isr_q & ~bus.data_i[CH_NUM-1:0]) | evt_s;
    end else begin
      isr_d = isr_q | evt_s;
    end
    if (wr_ier_s) begin
      ier_d = bus.data_i[CH_NUM-1:0];
    end else begin
      ier_d = ier_q;
    end
    irq_vec_d = isr_d & ier_d;
    irq_d     = |irq_vec_d;
  end

  // Read mux over the pre-edge register state; data_o holds when not reading.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.addr_i == A_GSTART) begin
      rdata_s[CH_NUM-1:0] = en_q;
    end else if (bus.addr_i == A_ISR) begin
      rdata_s[CH_NUM-1:0] = isr_q;
    end else if (bus.addr_i == A_IER) begin
      rdata_s[CH_NUM-1:0] = ier_q;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch_hit_s[c]) begin
          case (bus.addr_i[3:2])
            2'b00:   rdata_s[1:0]           = {oneshot_q[c], en_q[c]};
            2'b01:   rdata_s[PSC_WIDTH-1:0] = psc_q[c];
            2'b10:   rdata_s[CNT_WIDTH-1:0] = load_q[c];
            default: rdata_s[CNT_WIDTH-1:0] = count_q[c];
          endcase
        end else begin
          rdata_s = rdata_s;
        end
      end
    end
    if (bus.data_rd_i) begin
      data_o_d = rdata_s;
    end else begin
      data_o_d = data_o_q;
    end
  end

  // State registers; reset aborts every channel without raising an event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q      <= {CH_NUM{1'b0}};
      oneshot_q <= {CH_NUM{1'b0}};
      isr_q     <= {CH_NUM{1'b0}};
      ier_q     <= {CH_NUM{1'b0}};
      irq_vec_q <= {CH_NUM{1'b0}};
      irq_q     <= 1'b0;
      data_o_q  <= 32'h0000_0000;
      for (int c = 0; c < CH_NUM; c++) begin
        psc_q[c]   <= {PSC_WIDTH{1'b0}};
        pcnt_q[c]  <= {PSC_WIDTH{1'b0}};
        load_q[c]  <= {CNT_WIDTH{1'b0}};
        count_q[c] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      isr_q     <= isr_d;
      ier_q     <= ier_d;
      irq_vec_q <= irq_vec_d;
      irq_q     <= irq_d;
      data_o_q  <= data_o_d;
      psc_q     <= psc_d;
      pcnt_q    <= pcnt_d;
      load_q    <= load_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/pa_perips_timer_mc.md
# pa_perips_timer_mc

Multi-channel, parametrised successor to the single-channel peripheral timer, sitting on the peripheral register bus beside the other `pa_perips_*` blocks.
- Provides `CH_NUM` independent down-counters. Each channel has its own prescaler, reload value and periodic/one-shot mode.
- Per-channel interrupt flags are W1C, gated by per-channel interrupt enables, and OR-reduced to a single `irq_o`.
- A global start register starts any subset of channels on the same clock edge, for phase-aligned timing.

## Interface
Parameters:
- `CH_NUM`, default 4: number of channels; legal range 1..8.
- `CNT_WIDTH`, default 32: width of the counter and LOAD register; legal range 1..32.
- `PSC_WIDTH`, default 16: width of the prescaler register and counter; legal range 1..32.

Ports:
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous assert, active-high.
- `addr_i` in 8: byte address of the register.
- `data_rd_i` in 1: read strobe.
- `data_we_i` in 1: write strobe.
- `data_i` in 32: write data.
- `data_o` out 32: registered read data.
- `irq_o` out 1: `|(ISR & IER)`.
- `irq_vec_o` out CH_NUM: `ISR & IER`, one bit per channel.

## Operation
Register map (unmapped addresses read 0, writes to them are ignored; bits above a field's width read 0 and are ignored on write):
- 0x00 GSTART:
  - Read returns the EN vector of all channels.
  - Writing 1 to bit c starts channel c if it is idle. Writing 0 has no effect.
- 0x04 ISR: bit c is the event flag of channel c. Writing 1 clears the bit.
- 0x08 IER: bit c is the interrupt enable of channel c. Read/write.
- 0x10+0x10·c, CHc_CR: [0] EN, [1] ONESHOT. Read/write.
- 0x14+0x10·c, CHc_PSC: [PSC_WIDTH-1:0] prescale value; the divide ratio is PSC+1.
- 0x18+0x10·c, CHc_LOAD: [CNT_WIDTH-1:0] reload value.
- 0x1C+0x10·c, CHc_COUNT: current count. Read-only.

Per-channel behaviour:
- **Start.** Triggered by a 0→1 transition of EN, from either a CR write or GSTART. On that edge COUNT <= LOAD and the prescale counter pcnt <= 0. Writing EN=1 to a running channel does not restart it.
- **Running (EN=1):**
  - tick = (pcnt == PSC).
  - pcnt increments each cycle and wraps to 0 on tick.
  - On a tick with COUNT != 0: COUNT <= COUNT-1.
  - On a tick with COUNT == 0 (event): ISR[c] <= 1.
    - Periodic mode: COUNT <= LOAD.
    - One-shot mode: EN <= 0 and COUNT stays 0.
- **Period.** Exactly (LOAD+1)·(PSC+1) cycles between events. LOAD=0 with PSC=0 gives an event every cycle.
- **Idle (EN=0).** pcnt is held at 0 and COUNT holds its last value. No events occur.
- **Register writes while running.** LOAD and PSC may be written at any time:
  - A new LOAD takes effect at the next reload or start.
  - A new PSC takes effect immediately in the tick compare. If pcnt is already > PSC, pcnt counts on to the wrap at 2^PSC_WIDTH-1 → 0.

Priorities (same cycle):
- ISR set by an event and a W1C of the same bit: the set wins, so the bit stays 1.
- A CR write vs. internal EN changes: the CR write wins.
  - CR write of EN=0 in an event cycle: the channel stops, and ISR is still set.
  - CR write of EN=1 in the one-shot event cycle: the channel stays enabled, COUNT <= LOAD and pcnt <= 0 (restart).
- GSTART and a CR write to the same channel: the CR write wins.

## Timing
- Reads:
  - `data_o` is registered. It updates on the edge after a cycle in which `data_rd_i`=1, and holds its value otherwise.
  - Read data reflects register state before that edge.
- Writes take effect on the edge of the cycle with `data_we_i`=1.
- A start written on edge t0 has its first event on edge t0+(LOAD+1)·(PSC+1).
- ISR and `irq_o` are registered. `irq_o` asserts on the same edge ISR sets, with no extra delay.
- Reset: all registers, pcnt, `data_o`, `irq_o` and `irq_vec_o` are 0. Reset mid-count aborts the channel immediately, with no event.

## Test plan
- **Periodic, small values.** Setup: CH0 PSC=0, LOAD=3, IER=1, CR=1.
  - ISR[0] and `irq_o` rise 4 cycles after the enable edge.
  - COUNT reads 3,2,1,0,3.
  - After a W1C, the next event comes 4 cycles later.
- **One-shot with prescaler.** Setup: CH1 PSC=2, LOAD=1, CR=3.
  - A single event 6 cycles after enable.
  - After the event: EN=0, COUNT=0, and no further event over 50 cycles.
- **Synchronised start.** Setup: CH0 and CH2 with LOAD=9, PSC=1, then GSTART=0x5.
  - Both ISR bits set on the same edge, 20 cycles after the write.
  - GSTART reads 0x5.
- **W1C/event collision.** Setup: PSC=0, LOAD=0; W1C ISR[0] on every cycle.
  - ISR[0] stays 1.
  - IER=0 masks `irq_o` while ISR still reads 1.
- **Width and address boundaries.** Setup: CNT_WIDTH=8.
  - Write LOAD=0xFFFF_FF12; readback is 0x12.
  - A read at 0xFC returns 0; a write there changes nothing.
  - A restart after a LOAD change uses the new value.
- **Reset mid-count.** Setup: CH0 running with LOAD=100; assert `rst_i` for 1 cycle.
  - All reads return 0 and `irq_o`=0.
  - No event occurs without a new start.
